// File: rtl/bmlp_compute_unit.sv
// Datapath of the binary-MLP inference engine: gated-clock MAC accumulator,
// 128x1 activation register file and the final class compare.
module bmlp_compute_unit #(
  parameter int ACC_W    = 15,
  parameter int HID_W    = 7,
  parameter int RF_DEPTH = 128
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [2:0]                  layer,
  input  logic                        g_reg_rst7,
  input  logic                        rf_wen,
  input  logic                        rf_ren,
  input  logic [$clog2(RF_DEPTH)-1:0] rf_waddr,
  input  logic [$clog2(RF_DEPTH)-1:0] rf_raddr,
  input  logic [8:0]                  d9,
  input  logic                        w,
  output logic                        bin_class,
  output logic                        rf_d1,
  output logic [ACC_W-1:0]            tb_g_reg_in,
  output logic [ACC_W-1:0]            tb_accum1,
  output logic [HID_W-1:0]            tb_accum2,
  output logic [ACC_W-1:0]            tb_gated_reg_q,
  output logic                        tb_gated_clk,
  output logic [HID_W-1:0]            tb_adder7_A,
  output logic [HID_W-1:0]            tb_adder7_B
);

  localparam logic [2:0] LAYER_IN  = 3'b001;
  localparam logic [2:0] LAYER_NEG = 3'b010;
  localparam logic [2:0] LAYER_CLS = 3'b100;

  logic                 en_lat_q;
  logic                 gclk_s;
  logic                 acc_rst_n_s;
  logic [ACC_W-1:0]     acc_q;
  logic [ACC_W-1:0]     acc_d;
  logic [ACC_W-1:0]     d_ext_s;
  logic [ACC_W-1:0]     term_s;
  logic [ACC_W-1:0]     accum1_s;
  logic [HID_W-1:0]     add_a_s;
  logic [HID_W-1:0]     add_b_s;
  logic [HID_W-1:0]     accum2_s;
  logic                 b_neg_s;
  logic                 act_s;
  logic                 bin_class_q;
  logic                 bin_class_d;
  logic                 rf_rd_s;
  logic                 mem_q [RF_DEPTH];

  // Enable latch is transparent only while clk is low, so the AND gate cannot glitch.
  always_latch begin
    if (!clk) begin
      en_lat_q = (layer != LAYER_CLS);
    end
  end

  assign gclk_s      = clk & en_lat_q;
  assign acc_rst_n_s = rst & g_reg_rst7;
  assign act_s       = ~acc_q[ACC_W-1];

  // Adder operands and accumulator next value.
  always_comb begin
    d_ext_s  = {{(ACC_W-9){1'b0}}, d9};
    term_s   = w ? d_ext_s : ({ACC_W{1'b0}} - d_ext_s);
    accum1_s = acc_q + term_s;
    add_a_s  = acc_q[HID_W-1:0];
    // xnor(rf_d1, w) = 0 means -1; the negated output layer flips that sign.
    b_neg_s  = (~(rf_rd_s ^ w)) ^ (layer == LAYER_NEG) ? 1'b0 : 1'b1;
    add_b_s  = b_neg_s ? {HID_W{1'b1}} : {{(HID_W-1){1'b0}}, 1'b1};
    accum2_s = add_a_s + add_b_s;
    if (layer == LAYER_IN) begin
      acc_d = accum1_s;
    end else begin
      acc_d = {{(ACC_W-HID_W){accum2_s[HID_W-1]}}, accum2_s};
    end
  end

  // Accumulator on the gated clock, cleared by either reset.
  always_ff @(posedge gclk_s or negedge acc_rst_n_s) begin
    if (!acc_rst_n_s) begin
      acc_q <= {ACC_W{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  // Class decision: next-state select.
  always_comb begin
    if (layer == LAYER_CLS) begin
      bin_class_d = acc_q[ACC_W-1];
    end else begin
      bin_class_d = bin_class_q;
    end
  end

  // Class decision register on the free-running clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_class_q <= 1'b0;
    end else begin
      bin_class_q <= bin_class_d;
    end
  end

  // Activation store, deliberately unreset so activations survive per-neuron resets.
  always_ff @(posedge clk) begin
    if (rf_wen) begin
      mem_q[rf_waddr] <= act_s;
    end
  end

  assign rf_rd_s        = rf_ren ? mem_q[rf_raddr] : 1'b0;
  assign rf_d1          = rf_rd_s;
  assign bin_class      = bin_class_q;
  assign tb_g_reg_in    = acc_d;
  assign tb_accum1      = accum1_s;
  assign tb_accum2      = accum2_s;
  assign tb_gated_reg_q = acc_q;
  assign tb_gated_clk   = gclk_s;
  assign tb_adder7_A    = add_a_s;
  assign tb_adder7_B    = add_b_s;

endmodule

// File: tb/tb_bmlp_compute_unit.sv
// Directed self-checking bench for bmlp_compute_unit.
module tb_bmlp_compute_unit;

  logic        clk;
  logic        rst;
  logic [2:0]  layer;
  logic        g_reg_rst7;
  logic        rf_wen;
  logic        rf_ren;
  logic [6:0]  rf_waddr;
  logic [6:0]  rf_raddr;
  logic [8:0]  d9;
  logic        w;
  logic        bin_class;
  logic        rf_d1;
  logic [14:0] tb_g_reg_in;
  logic [14:0] tb_accum1;
  logic [6:0]  tb_accum2;
  logic [14:0] tb_gated_reg_q;
  logic        tb_gated_clk;
  logic [6:0]  tb_adder7_A;
  logic [6:0]  tb_adder7_B;

  int checks = 0;
  int errors = 0;

  bmlp_compute_unit dut (
    .clk            (clk),
    .rst            (rst),
    .layer          (layer),
    .g_reg_rst7     (g_reg_rst7),
    .rf_wen         (rf_wen),
    .rf_ren         (rf_ren),
    .rf_waddr       (rf_waddr),
    .rf_raddr       (rf_raddr),
    .d9             (d9),
    .w              (w),
    .bin_class      (bin_class),
    .rf_d1          (rf_d1),
    .tb_g_reg_in    (tb_g_reg_in),
    .tb_accum1      (tb_accum1),
    .tb_accum2      (tb_accum2),
    .tb_gated_reg_q (tb_gated_reg_q),
    .tb_gated_clk   (tb_gated_clk),
    .tb_adder7_A    (tb_adder7_A),
    .tb_adder7_B    (tb_adder7_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_acc;
    #1 g_reg_rst7 = 1'b0;
    #1 g_reg_rst7 = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (tb_gated_reg_q !== 15'h0000) begin
      errors++; $display("FAIL reset_q got %h want %h", tb_gated_reg_q, 15'h0000);
    end
    checks++;
    if (bin_class !== 1'b0) begin
      errors++; $display("FAIL reset_class got %b want %b", bin_class, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_input_pos;
    clear_acc();
    layer = 3'b001; w = 1'b1; d9 = 9'd1;
    repeat (30) @(negedge clk);
    checks++;
    if (tb_gated_reg_q !== 15'd30) begin
      errors++; $display("FAIL in_pos_q got %0d want %0d", tb_gated_reg_q, 30);
    end
    checks++;
    if (tb_accum1 !== 15'd31) begin
      errors++; $display("FAIL in_pos_accum1 got %0d want %0d", tb_accum1, 31);
    end
    layer = 3'b100; rf_wen = 1'b1; rf_waddr = 7'd0;
    @(negedge clk);
    rf_wen = 1'b0; rf_ren = 1'b1; rf_raddr = 7'd0;
    #1;
    checks++;
    if (rf_d1 !== 1'b1) begin
      errors++; $display("FAIL in_pos_mem0 got %b want %b", rf_d1, 1'b1);
    end
    checks++;
    if (tb_gated_reg_q !== 15'd30) begin
      errors++; $display("FAIL in_pos_hold got %0d want %0d", tb_gated_reg_q, 30);
    end
  endtask

  task automatic test_input_neg;
    @(negedge clk);
    clear_acc();
    layer = 3'b001; w = 1'b0; d9 = 9'd1;
    repeat (30) @(negedge clk);
    checks++;
    if (tb_gated_reg_q !== 15'h7FE2) begin
      errors++; $display("FAIL in_neg_q got %h want %h", tb_gated_reg_q, 15'h7FE2);
    end
    checks++;
    if (tb_g_reg_in !== 15'h7FE1) begin
      errors++; $display("FAIL in_neg_dreg got %h want %h", tb_g_reg_in, 15'h7FE1);
    end
    layer = 3'b100; rf_wen = 1'b1; rf_waddr = 7'd1;
    @(negedge clk);
    rf_wen = 1'b0; rf_ren = 1'b1; rf_raddr = 7'd1;
    #1;
    checks++;
    if (rf_d1 !== 1'b0) begin
      errors++; $display("FAIL in_neg_mem1 got %b want %b", rf_d1, 1'b0);
    end
    rf_ren = 1'b0;
    #1;
    checks++;
    if (rf_d1 !== 1'b0) begin
      errors++; $display("FAIL rf_ren_off got %b want %b", rf_d1, 1'b0);
    end
  endtask

  task automatic test_input_large;
    @(negedge clk);
    clear_acc();
    layer = 3'b001; w = 1'b1; d9 = 9'd511;
    repeat (64) @(negedge clk);
    checks++;
    if (tb_gated_reg_q !== 15'h7FC0) begin
      errors++; $display("FAIL in_large_q got %h want %h", tb_gated_reg_q, 15'h7FC0);
    end
    // Write on this edge must use the pre-edge q (bit 14 set, act 0) while q wraps.
    rf_wen = 1'b1; rf_waddr = 7'd2;
    @(negedge clk);
    rf_wen = 1'b0; layer = 3'b100;
    checks++;
    if (tb_gated_reg_q !== 15'd447) begin
      errors++; $display("FAIL in_wrap_q got %0d want %0d", tb_gated_reg_q, 447);
    end
    rf_ren = 1'b1; rf_raddr = 7'd2;
    #1;
    checks++;
    if (rf_d1 !== 1'b0) begin
      errors++; $display("FAIL in_large_mem2 got %b want %b", rf_d1, 1'b0);
    end
  endtask

  task automatic test_hidden;
    @(negedge clk);
    clear_acc();
    layer = 3'b000; rf_ren = 1'b1; rf_raddr = 7'd0; w = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (tb_gated_reg_q !== 15'h7FEC) begin
      errors++; $display("FAIL hid_q got %h want %h", tb_gated_reg_q, 15'h7FEC);
    end
    checks++;
    if (tb_adder7_B !== 7'h7F) begin
      errors++; $display("FAIL hid_b_neg got %h want %h", tb_adder7_B, 7'h7F);
    end
    checks++;
    if (tb_adder7_A !== 7'h6C || tb_accum2 !== 7'h6B) begin
      errors++; $display("FAIL hid_adder got A=%h S=%h want A=%h S=%h", tb_adder7_A, tb_accum2, 7'h6C, 7'h6B);
    end
    checks++;
    if (tb_g_reg_in !== 15'h7FEB) begin
      errors++; $display("FAIL hid_sext got %h want %h", tb_g_reg_in, 15'h7FEB);
    end
    w = 1'b1;
    #1;
    checks++;
    if (tb_adder7_B !== 7'h01) begin
      errors++; $display("FAIL hid_b_pos got %h want %h", tb_adder7_B, 7'h01);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (tb_gated_reg_q !== 15'h7FF1) begin
      errors++; $display("FAIL hid_up got %h want %h", tb_gated_reg_q, 15'h7FF1);
    end
  endtask

  task automatic test_classify;
    @(negedge clk);
    clear_acc();
    layer = 3'b000; rf_ren = 1'b1; rf_raddr = 7'd0; w = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tb_gated_reg_q !== 15'd3) begin
      errors++; $display("FAIL cls_a got %0d want %0d", tb_gated_reg_q, 3);
    end
    layer = 3'b010;
    #1;
    checks++;
    if (tb_adder7_B !== 7'h7F) begin
      errors++; $display("FAIL cls_b_swap got %h want %h", tb_adder7_B, 7'h7F);
    end
    @(posedge clk);
    #1;
    checks++;
    if (tb_gated_clk !== 1'b1) begin
      errors++; $display("FAIL gclk_on got %b want %b", tb_gated_clk, 1'b1);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (tb_gated_reg_q !== 15'h7FFF) begin
      errors++; $display("FAIL cls_diff got %h want %h", tb_gated_reg_q, 15'h7FFF);
    end
    layer = 3'b100;
    @(posedge clk);
    #2;
    checks++;
    if (tb_gated_clk !== 1'b0) begin
      errors++; $display("FAIL gclk_off got %b want %b", tb_gated_clk, 1'b0);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (bin_class !== 1'b1) begin
      errors++; $display("FAIL cls_result got %b want %b", bin_class, 1'b1);
    end
    checks++;
    if (tb_gated_reg_q !== 15'h7FFF) begin
      errors++; $display("FAIL cls_frozen got %h want %h", tb_gated_reg_q, 15'h7FFF);
    end
    clear_acc();
    checks++;
    if (tb_gated_reg_q !== 15'h0000 || bin_class !== 1'b1) begin
      errors++; $display("FAIL acc_clear_only got q=%h cls=%b want q=%h cls=%b", tb_gated_reg_q, bin_class, 15'h0000, 1'b1);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    layer = 3'b000; w = 1'b1; rf_raddr = 7'd0;
    repeat (2) @(negedge clk);
    layer = 3'b100;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (tb_gated_reg_q !== 15'h0000 || bin_class !== 1'b0) begin
      errors++; $display("FAIL async_rst got q=%h cls=%b want q=%h cls=%b", tb_gated_reg_q, bin_class, 15'h0000, 1'b0);
    end
    rf_ren = 1'b1; rf_raddr = 7'd0;
    #1;
    checks++;
    if (rf_d1 !== 1'b1) begin
      errors++; $display("FAIL rst_keeps_mem0 got %b want %b", rf_d1, 1'b1);
    end
    rf_raddr = 7'd1;
    #1;
    checks++;
    if (rf_d1 !== 1'b0) begin
      errors++; $display("FAIL rst_keeps_mem1 got %b want %b", rf_d1, 1'b0);
    end
    rst = 1'b1;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    // q is 0 here, so the write stores act = 1 over the stored 0.
    rf_ren = 1'b1; rf_raddr = 7'd1; rf_wen = 1'b1; rf_waddr = 7'd1;
    #1;
    checks++;
    if (rf_d1 !== 1'b0) begin
      errors++; $display("FAIL rw_old got %b want %b", rf_d1, 1'b0);
    end
    @(posedge clk);
    #1;
    rf_wen = 1'b0;
    checks++;
    if (rf_d1 !== 1'b1) begin
      errors++; $display("FAIL rw_new got %b want %b", rf_d1, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b0; g_reg_rst7 = 1'b1; layer = 3'b100;
    rf_wen = 1'b0; rf_ren = 1'b0; rf_waddr = 7'd0; rf_raddr = 7'd0;
    d9 = 9'd0; w = 1'b0;
    test_reset();
    test_input_pos();
    test_input_neg();
    test_input_large();
    test_hidden();
    test_classify();
    test_async_reset();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
